alu_pipe_mdu: RTL and testbench

//  Parametrised sequential successor to the combinational 3-bit-op ALU: extended op set plus iterative multiply/divide.

---
 rtl/alu_pipe_mdu_pkg.sv | 28 ++
 rtl/alu_pipe_mdu_iter_muldiv.sv | 66 ++++++
 rtl/alu_pipe_mdu.sv | 162 ++++++++++++++++
 tb/tb_alu_pipe_mdu.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_mdu_pkg.sv
// Shared definitions for alu_pipe_mdu: op codes and handshake FSM states.
package alu_pipe_mdu_pkg;

  // Op codes 0-5 keep the legacy 3-bit ALU encoding; 13-15 are reserved.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SRL  = 4'd4,
    OP_SRA  = 4'd5,
    OP_SLL  = 4'd6,
    OP_SLT  = 4'd7,
    OP_SLTU = 4'd8,
    OP_MUL  = 4'd9,
    OP_MULU = 4'd10,
    OP_DIV  = 4'd11,
    OP_DIVU = 4'd12
  } op_t;

  // Handshake FSM states, also exported on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_pipe_mdu_iter_muldiv.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, one bit per cycle.
// hi/lo/dsr are shared: multiply uses {hi,lo} as product/multiplier with dsr as
// multiplicand; divide uses hi as partial remainder, lo as dividend/quotient, dsr as divisor.
// done is asserted during the last iteration and res_lo/res_hi carry that
// iteration's outcome, so the caller can register the final answer on the same edge.
module alu_pipe_mdu_iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);
  localparam int CW = $clog2(WIDTH);

  logic             running;
  logic             mode_div;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, dsr;
  logic [WIDTH:0]   mul_sum, trial, diff;
  logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo;

  // One iteration of either algorithm, computed from the current registers.
  always_comb begin
    mul_sum = {1'b0, hi} + ({(WIDTH+1){lo[0]}} & {1'b0, dsr});
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], lo[WIDTH-1:1]};
    trial   = {hi, lo[WIDTH-1]};
    diff    = trial - {1'b0, dsr};
    div_hi  = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    div_lo  = {lo[WIDTH-2:0], ~diff[WIDTH]};
    res_lo  = mode_div ? div_lo : mul_lo;
    res_hi  = mode_div ? div_hi : mul_hi;
    done    = running && (cnt == CW'(WIDTH-1));
  end

  // Load operands on start, then step WIDTH times; reset aborts any iteration.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running  <= 1'b0;
      mode_div <= 1'b0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      dsr      <= '0;
    end else if (start) begin
      running  <= 1'b1;
      mode_div <= is_div;
      cnt      <= '0;
      hi       <= '0;
      lo       <= opa;
      dsr      <= opb;
    end else if (running) begin
      hi  <= res_hi;
      lo  <= res_lo;
      cnt <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe_mdu.sv
// Sequential ALU with iterative multiply/divide behind valid/ready handshakes.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; a producer holds its payload stable until then, ready may depend on
// the consumer's ready (in_ready follows out_ready while a result waits).
module alu_pipe_mdu
  import alu_pipe_mdu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             err,
  output state_t           dbg_state
);

  state_t             state, state_nx;
  logic               live;
  logic               accept, md_start, md_done;
  logic               is_md, is_div, is_sgn, div_zero, a_neg, b_neg;
  logic               alu_err;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   alu_res, a_mag, b_mag, md_lo, md_hi, q_fix, r_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic               lat_div, lat_neg_q, lat_neg_r;

  assign shamt     = b[SHW-1:0];
  assign accept    = in_valid && in_ready;
  assign md_start  = accept && is_md && !div_zero;
  assign in_ready  = live && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
  assign out_valid = (state == ST_DONE);
  assign dbg_state = state;

  // Single-cycle ALU datapath; anything outside the op table is flagged.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(a) >>> shamt);
      OP_SLL:  alu_res = a << shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MUL, OP_MULU, OP_DIV, OP_DIVU: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // Multiply/divide decode and magnitude pre-processing for the unsigned engine.
  always_comb begin
    is_md  = 1'b0;
    is_div = 1'b0;
    is_sgn = 1'b0;
    case (op)
      OP_MUL:  begin is_md = 1'b1; is_sgn = 1'b1; end
      OP_MULU: begin is_md = 1'b1; end
      OP_DIV:  begin is_md = 1'b1; is_div = 1'b1; is_sgn = 1'b1; end
      OP_DIVU: begin is_md = 1'b1; is_div = 1'b1; end
      default: ;
    endcase
    div_zero = is_div && (b == '0);
    a_neg    = is_sgn && a[WIDTH-1];
    b_neg    = is_sgn && b[WIDTH-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
  end

  // Sign post-processing: product/quotient negative when operand signs differ,
  // remainder follows the dividend. MIN / -1 falls out as quotient MIN, remainder 0.
  always_comb begin
    prod_fix = lat_neg_q ? -{md_hi, md_lo} : {md_hi, md_lo};
    q_fix    = lat_neg_q ? -md_lo : md_lo;
    r_fix    = lat_neg_r ? -md_hi : md_hi;
  end

  alu_pipe_mdu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (md_start),
    .is_div  (is_div),
    .opa     (a_mag),
    .opb     (b_mag),
    .done    (md_done),
    .res_lo  (md_lo),
    .res_hi  (md_hi)
  );

  // in_ready stays low through reset and rises one edge after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) live <= 1'b0;
    else          live <= 1'b1;
  end

  // Handshake FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Next state: accepts from IDLE or from DONE (back-to-back) pick BUSY or DONE.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept)                                state_nx = md_start ? ST_BUSY : ST_DONE;
        else if ((state == ST_DONE) && out_ready)  state_nx = ST_IDLE;
      end
      ST_BUSY: if (md_done) state_nx = ST_DONE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Sign flags captured with the operands so later input changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_div   <= 1'b0;
      lat_neg_q <= 1'b0;
      lat_neg_r <= 1'b0;
    end else if (md_start) begin
      lat_div   <= is_div;
      lat_neg_q <= a_neg ^ b_neg;
      lat_neg_r <= a_neg;
    end
  end

  // Output registers: immediate results on accept, engine results on completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result    <= '0;
      result_hi <= '0;
      err       <= 1'b0;
    end else if ((state == ST_BUSY) && md_done) begin
      result    <= lat_div ? q_fix : prod_fix[WIDTH-1:0];
      result_hi <= lat_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
      err       <= 1'b0;
    end else if (accept && !md_start) begin
      if (div_zero) begin
        result    <= '1;
        result_hi <= a;
        err       <= 1'b1;
      end else begin
        result    <= alu_res;
        result_hi <= '0;
        err       <= alu_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe_mdu.sv
// Scoreboard bench for alu_pipe_mdu (WIDTH=32): directed corners, random traffic, reset abort.
module tb_alu_pipe_mdu;
  import alu_pipe_mdu_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    op = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result, result_hi;
  logic          err;
  state_t        dbg_state;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  exp_t         exp_q[$];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_pass = 0;
  bit           ordy_rand = 1'b0;
  bit           seen = 1'b0;
  logic [2*W:0] snap;

  localparam int ND = 14;
  localparam logic [3:0]   D_OP [ND] = '{4'd0, 4'd5, 4'd4, 4'd7, 4'd8, 4'd9, 4'd11, 4'd12,
                                         4'd11, 4'd13, 4'd1, 4'd6, 4'd10, 4'd15};
  localparam logic [W-1:0] D_A  [ND] = '{32'hC0000011, 32'hC0000011, 32'hC0000011, 32'hFFFFFFFF,
                                         32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7,
                                         32'h80000000, 32'h12345678, 32'd3, 32'h00000001,
                                         32'hFFFFFFFF, 32'd9};
  localparam logic [W-1:0] D_B  [ND] = '{32'hC0000011, 32'd1, 32'd1, 32'd1,
                                         32'd1, 32'd3, 32'd2, 32'd0,
                                         32'hFFFFFFFF, 32'd5, 32'd5, 32'd31,
                                         32'hFFFFFFFF, 32'd9};

  alu_pipe_mdu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [2*W:0] act, input logic [2*W:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference model: plain 64-bit arithmetic on the op definitions.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.res = '0; e.hi = '0; e.err = 1'b0; e.lat = 1; e.acc = 0;
    case (o)
      4'd0:  e.res = x + y;
      4'd1:  e.res = x - y;
      4'd2:  e.res = x & y;
      4'd3:  e.res = x | y;
      4'd4:  e.res = x >> y[4:0];
      4'd5:  begin p = 64'(sx >>> y[4:0]); e.res = p[31:0]; end
      4'd6:  e.res = x << y[4:0];
      4'd7:  e.res = (sx < sy) ? 32'd1 : 32'd0;
      4'd8:  e.res = (x < y) ? 32'd1 : 32'd0;
      4'd9:  begin p = 64'(sx * sy); e.res = p[31:0]; e.hi = p[63:32]; e.lat = W + 1; end
      4'd10: begin p = {32'h0, x} * {32'h0, y}; e.res = p[31:0]; e.hi = p[63:32]; e.lat = W + 1; end
      4'd11: begin
        if (y == 0) begin e.res = '1; e.hi = x; e.err = 1'b1; end
        else begin q = sx / sy; r = sx % sy; e.res = q[31:0]; e.hi = r[31:0]; e.lat = W + 1; end
      end
      4'd12: begin
        if (y == 0) begin e.res = '1; e.hi = x; e.err = 1'b1; end
        else begin e.res = x / y; e.hi = x % y; e.lat = W + 1; end
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Driver: present a request at a negedge, hold until accepted, push expectation.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output int waited);
    exp_t e;
    in_valid = 1'b1; op = o; a = x; b = y; waited = 0;
    #2;
    while (!in_ready && waited < 300) begin
      @(negedge clk); #2;
      waited++;
    end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL accept_timeout: op=%0d not accepted, state %s", o, dbg_state.name());
    end else begin
      e = model(o, x, y);
      e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() > 0) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d outstanding, state %s", exp_q.size(), dbg_state.name());
      exp_q.delete();
    end
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Consumer back-pressure, randomized during the random phase.
  initial begin
    forever begin
      @(negedge clk);
      if (ordy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares each transferred result with the queue head, plus
  // latency, hold-while-stalled and in_ready rules.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!reset_n) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          snap = {result, result_hi, err};
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_output: result=%h with nothing outstanding", result);
          end else begin
            chk("latency", 65'(cyc - exp_q[0].acc + 1), 65'(exp_q[0].lat));
          end
        end else begin
          chk("hold_stable", {result, result_hi, err}, snap);
        end
        if (!out_ready) begin
          chk("stall_in_ready", 65'(in_ready), 65'(0));
        end else begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("result", 65'(result), 65'(e.res));
            chk("result_hi", 65'(result_hi), 65'(e.hi));
            chk("err", 65'(err), 65'(e.err));
          end
          seen = 1'b0;
        end
      end else if (exp_q.size() > 0 && exp_q[0].lat > 1 && cyc >= exp_q[0].acc) begin
        chk("busy_in_ready", 65'(in_ready), 65'(0));
      end
    end
  end

  // Stimulus sequence.
  initial begin
    int w;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_in_ready", 65'(in_ready), 65'(0));
    chk("rst_out_valid", 65'(out_valid), 65'(0));
    chk("rst_outputs", {result, result_hi, err}, 65'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); #2;
    chk("in_ready_after_release", 65'(in_ready), 65'(1));
    @(negedge clk);

    out_ready = 1'b1;
    for (int i = 0; i < ND; i++) begin
      logic [3:0]   o;
      logic [W-1:0] x, y;
      o = D_OP[i]; x = D_A[i]; y = D_B[i];
      issue(o, x, y, w);
    end
    drain();

    // Stall 5 cycles, then release together with a new request.
    out_ready = 1'b0;
    issue(4'd0, 32'd5, 32'd6, w);
    idle(5);
    out_ready = 1'b1;
    issue(4'd0, 32'd7, 32'd8, w);
    chk("b2b_accept_same_cycle", 65'(w), 65'(0));
    drain();

    // Random traffic with random back-pressure.
    ordy_rand = 1'b1;
    for (int i = 0; i < 250; i++) begin
      logic [3:0] o;
      idle($urandom_range(0, 2));
      o = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 12)) : 4'($urandom_range(0, 15));
      issue(o, rand_operand(), rand_operand(), w);
    end
    ordy_rand = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset in the middle of a multiply.
    issue(4'd0, 32'd40, 32'd2, w);
    drain();
    @(negedge clk);
    issue(4'd9, 32'd12345, 32'd678, w);
    idle(9);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 65'(out_valid), 65'(0));
    chk("midrst_outputs", {result, result_hi, err}, 65'(0));
    chk("midrst_in_ready", 65'(in_ready), 65'(0));
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue(4'd0, 32'd1, 32'd2, w);
    drain();
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Watchdog against a wedged design.
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, state %s", dbg_state.name());
    $fatal(1, "watchdog");
  end

endmodule
